// File: rtl/line_memory.sv
// Dual-port (I/D) line-granular main memory with req/ack handshake and fixed access latency.
// Optional MEM_STATS_EN adds saturating read/write completion counters.

module line_memory_port #(
  parameter int IDX_W   = 6,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [IDX_W-1:0]  line_idx,
  input  logic [LINE_W-1:0] wdata,
  output logic              complete,
  output logic              c_we,
  output logic [IDX_W-1:0]  c_line,
  output logic [LINE_W-1:0] c_wdata,
  output logic              ack
);
  localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               accept;
  logic               we_q;
  logic [IDX_W-1:0]   line_q;
  logic [LINE_W-1:0]  wdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      line_q  <= line_idx;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept = 1'b1;
        if (LATENCY == 1) begin
          complete = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
          cnt_nx   = CNT_W'(CNT_LOAD);
        end
      end
      WAIT: if (cnt == '0) begin
        complete = 1'b1;
        state_nx = DONE;
      end else begin
        cnt_nx = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the acceptance edge is also the completion edge, so use live inputs.
  assign c_we    = (state == IDLE) ? we       : we_q;
  assign c_line  = (state == IDLE) ? line_idx : line_q;
  assign c_wdata = (state == IDLE) ? wdata    : wdata_q;
  assign ack     = (state == DONE);
endmodule

module line_memory #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_req,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] i_wdata,
  output logic                         i_ack,
  output logic [LINE_WORDS*WORD_W-1:0] i_rdata,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] d_wdata,
  output logic                         d_ack,
  output logic [LINE_WORDS*WORD_W-1:0] d_rdata
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]                  stat_reads,
  output logic [31:0]                  stat_writes
`endif
);
  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = (ADDR_W > OFF_W) ? ADDR_W - OFF_W : 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Port 0 = I, port 1 = D; D is processed last so it wins same-line write collisions.
  logic [1:0]             req, we, ack, complete, c_we;
  logic [1:0][IDX_W-1:0]  line_idx, c_line;
  logic [1:0][LINE_W-1:0] wdata, c_wdata, rd_line, rdata;

  assign req      = {d_req, i_req};
  assign we       = {d_we, i_we};
  assign wdata    = {d_wdata, i_wdata};
  assign line_idx = {IDX_W'(d_addr >> OFF_W), IDX_W'(i_addr >> OFF_W)};
  assign i_ack    = ack[0];
  assign d_ack    = ack[1];
  assign i_rdata  = rdata[0];
  assign d_rdata  = rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    line_memory_port #(.IDX_W(IDX_W), .LINE_W(LINE_W), .LATENCY(LATENCY)) u_port (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req[p]),
      .we       (we[p]),
      .line_idx (line_idx[p]),
      .wdata    (wdata[p]),
      .complete (complete[p]),
      .c_we     (c_we[p]),
      .c_line   (c_line[p]),
      .c_wdata  (c_wdata[p]),
      .ack      (ack[p])
    );
  end

  function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] line, input int k);
    word_addr = (ADDR_W'(line) << OFF_W) + ADDR_W'(k);
  endfunction

  always_comb begin
    rd_line = '0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < LINE_WORDS; k++)
        rd_line[p][k*WORD_W +: WORD_W] = mem[word_addr(c_line[p], k)];
  end

  // Reads sample pre-edge contents, giving read-before-write on same-edge collisions.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (reset_n && complete[p] && c_we[p])
        for (int k = 0; k < LINE_WORDS; k++)
          mem[word_addr(c_line[p], k)] <= c_wdata[p][k*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (complete[p] && !c_we[p]) rdata[p] <= rd_line[p];
    end
  end

`ifdef MEM_STATS_EN
  logic [1:0] rd_done, wr_done;
  assign rd_done = complete & ~c_we;
  assign wr_done = complete & c_we;

  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, c} + 33'({1'b0, inc[0]} + {1'b0, inc[1]});
    sat_add = s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else begin
      stat_reads  <= sat_add(stat_reads, rd_done);
      stat_writes <= sat_add(stat_writes, wr_done);
    end
  end
`endif
endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory (WORD_W=16, ADDR_W=8, LINE_WORDS=4, LATENCY=4).
// Stats checks are compiled in when MEM_STATS_EN is defined.
module tb_line_memory;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_we, d_req, d_we;
  logic [7:0]  i_addr, d_addr;
  logic [63:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic        i_ack, d_ack;
`ifdef MEM_STATS_EN
  logic [31:0] stat_reads, stat_writes;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [63:0] L12   = 64'h4444_3333_2222_1111;
  localparam logic [63:0] LFC   = 64'hdead_beef_0123_4567;
  localparam logic [63:0] OLD20 = 64'h2003_2002_2001_2000;
  localparam logic [63:0] NEW20 = 64'h2a03_2a02_2a01_2a00;
  localparam logic [63:0] I30   = 64'h3103_3102_3101_3100;
  localparam logic [63:0] D30   = 64'h3d03_3d02_3d01_3d00;
  localparam logic [63:0] OLD40 = 64'h4003_4002_4001_4000;
  localparam logic [63:0] NEW40 = 64'h4a03_4a02_4a01_4a00;

  line_memory #(.WORD_W(16), .ADDR_W(8), .LINE_WORDS(4), .LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata)
`ifdef MEM_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access; lat = edges from acceptance (inclusive) to ack, -1 on timeout.
  task automatic access(input bit dport, input logic we, input logic [7:0] addr,
                        input logic [63:0] wd, output int lat, output logic ack_after);
    if (dport) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    else       begin i_req = 1; i_we = we; i_addr = addr; i_wdata = wd; end
    tick();
    i_req = 0; d_req = 0;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      if ((dport ? d_ack : i_ack) === 1'b1) begin lat = e; break; end
      tick();
    end
    tick();
    ack_after = dport ? d_ack : i_ack;
  endtask

  // Both ports accepted on the same edge; returns each port's ack latency.
  task automatic both(input logic iwe, input logic [7:0] ia, input logic [63:0] iwd,
                      input logic dwe, input logic [7:0] da, input logic [63:0] dwd,
                      output int ilat, output int dlat);
    i_req = 1; i_we = iwe; i_addr = ia; i_wdata = iwd;
    d_req = 1; d_we = dwe; d_addr = da; d_wdata = dwd;
    tick();
    i_req = 0; d_req = 0;
    ilat = -1; dlat = -1;
    for (int e = 1; e <= 20; e++) begin
      if (i_ack === 1'b1 && ilat < 0) ilat = e;
      if (d_ack === 1'b1 && dlat < 0) dlat = e;
      if (ilat >= 0 && dlat >= 0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0; i_req = 1; d_req = 1; i_we = 0; d_we = 1;
    i_addr = 8'h00; d_addr = 8'h00; i_wdata = '0; d_wdata = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++; if ({i_ack, d_ack} !== 2'b00) $display("FAIL rst_ack got %b exp 00", {i_ack, d_ack}); else n_pass++;
      n_chk++; if (i_rdata !== 64'h0) $display("FAIL rst_i_rdata got %h exp 0", i_rdata); else n_pass++;
      n_chk++; if (d_rdata !== 64'h0) $display("FAIL rst_d_rdata got %h exp 0", d_rdata); else n_pass++;
    end
    i_req = 0; d_req = 0; reset_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_chk++; if ({i_ack, d_ack} !== 2'b00) $display("FAIL post_rst_ack got %b exp 00", {i_ack, d_ack}); else n_pass++;
    end
  endtask

  task automatic test_write_read();
    int lat; logic aa;
    access(1, 1, 8'h12, L12, lat, aa);
    n_chk++; if (lat !== 4) $display("FAIL wr_lat got %0d exp 4", lat); else n_pass++;
    n_chk++; if (aa !== 1'b0) $display("FAIL wr_ack_width got %b exp 0", aa); else n_pass++;
    n_chk++; if (d_rdata !== 64'h0) $display("FAIL wr_keeps_rdata got %h exp 0", d_rdata); else n_pass++;
    access(0, 0, 8'h10, '0, lat, aa);
    n_chk++; if (lat !== 4) $display("FAIL rd_lat got %0d exp 4", lat); else n_pass++;
    n_chk++; if (i_rdata !== L12) $display("FAIL rd_line got %h exp %h", i_rdata, L12); else n_pass++;
    n_chk++; if (i_rdata[15:0] !== 16'h1111) $display("FAIL rd_word0 got %h exp 1111", i_rdata[15:0]); else n_pass++;
    access(0, 1, 8'hFE, LFC, lat, aa);
    access(1, 0, 8'hFF, '0, lat, aa);
    n_chk++; if (d_rdata !== LFC) $display("FAIL top_line got %h exp %h", d_rdata, LFC); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int npulse = 0, last = 0, first = 0;
    i_req = 1; i_we = 0; i_addr = 8'hFC;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (i_ack === 1'b1) begin
        if (npulse == 0) first = e;
        else begin
          n_chk++; if (e - last !== 5) $display("FAIL b2b_period got %0d exp 5", e - last); else n_pass++;
        end
        npulse++; last = e;
      end
      if (npulse > 0) begin
        n_chk++; if (i_rdata !== LFC) $display("FAIL b2b_rdata got %h exp %h", i_rdata, LFC); else n_pass++;
      end
    end
    i_req = 0;
    tick();
    n_chk++; if (npulse !== 4) $display("FAIL b2b_pulses got %0d exp 4", npulse); else n_pass++;
    n_chk++; if (first !== 4) $display("FAIL b2b_first got %0d exp 4", first); else n_pass++;
  endtask

  task automatic test_same_edge();
    int lat, ilat, dlat; logic aa;
    access(1, 1, 8'h20, OLD20, lat, aa);
    both(0, 8'h22, '0, 1, 8'h21, NEW20, ilat, dlat);
    n_chk++; if (ilat !== 4 || dlat !== 4) $display("FAIL rw_acks got %0d/%0d exp 4/4", ilat, dlat); else n_pass++;
    n_chk++; if (i_rdata !== OLD20) $display("FAIL rw_old got %h exp %h", i_rdata, OLD20); else n_pass++;
    access(0, 0, 8'h23, '0, lat, aa);
    n_chk++; if (i_rdata !== NEW20) $display("FAIL rw_new got %h exp %h", i_rdata, NEW20); else n_pass++;
    both(1, 8'h30, I30, 1, 8'h31, D30, ilat, dlat);
    n_chk++; if (ilat !== 4 || dlat !== 4) $display("FAIL ww_acks got %0d/%0d exp 4/4", ilat, dlat); else n_pass++;
    access(1, 0, 8'h30, '0, lat, aa);
    n_chk++; if (d_rdata !== D30) $display("FAIL ww_winner got %h exp %h", d_rdata, D30); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic aa; logic seen = 0;
    access(1, 1, 8'h40, OLD40, lat, aa);
    d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = NEW40;
    tick();
    d_req = 0;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    for (int c = 0; c < 6; c++) begin
      if (d_ack === 1'b1) seen = 1;
      tick();
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL mid_rst_ack got %b exp 0", seen); else n_pass++;
    n_chk++; if (d_rdata !== 64'h0) $display("FAIL mid_rst_rdata got %h exp 0", d_rdata); else n_pass++;
    access(1, 0, 8'h42, '0, lat, aa);
    n_chk++; if (lat !== 4) $display("FAIL mid_rst_next_lat got %0d exp 4", lat); else n_pass++;
    n_chk++; if (d_rdata !== OLD40) $display("FAIL mid_rst_kept got %h exp %h", d_rdata, OLD40); else n_pass++;
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    int lat, ilat, dlat; logic aa;
    reset_n = 0; tick(); reset_n = 1;
    n_chk++; if (stat_reads !== 0 || stat_writes !== 0) $display("FAIL stats_clr got %0d/%0d exp 0/0", stat_reads, stat_writes); else n_pass++;
    both(0, 8'h10, '0, 0, 8'h12, '0, ilat, dlat);
    access(0, 0, 8'h20, '0, lat, aa);
    access(1, 1, 8'h50, NEW40, lat, aa);
    access(0, 1, 8'h54, NEW20, lat, aa);
    n_chk++; if (stat_reads !== 3) $display("FAIL stat_reads got %0d exp 3", stat_reads); else n_pass++;
    n_chk++; if (stat_writes !== 2) $display("FAIL stat_writes got %0d exp 2", stat_writes); else n_pass++;
    reset_n = 0; tick(); reset_n = 1;
    n_chk++; if (stat_reads !== 0 || stat_writes !== 0) $display("FAIL stats_rst got %0d/%0d exp 0/0", stat_reads, stat_writes); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_same_edge();
    test_reset_mid();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
